// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock,
// with a start/busy/done handshake and registered, held results.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on accepted start
    // SHIFT | one difference bit per cycle, WIDTH cycles
    // DONE  | one-cycle done pulse; diff/bout already valid
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] rd_next;

    assign x       = ra[0];
    assign y       = rb[0];
    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

    // A one-bit result register has nothing to shift in from above.
    generate
        if (WIDTH == 1) begin : g_w1
            assign rd_next = d;
        end else begin : g_wn
            assign rd_next = {d, rd[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rd  <= rd_next;
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= rd_next;
                        bout  <= br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, through a one-bit difference/borrow stage and a registered borrow. It is the subtracting counterpart of the team's adder cells. It trades latency for area in datapaths where operands arrive occasionally, and it presents a start/busy/done handshake to the surrounding control logic.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1 to 32.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset; sampled on rising edge of `clk`.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: minuend, captured on accepted `start`.
- `b` input WIDTH: subtrahend, captured on accepted `start`.
- `busy` output 1: high while bits are being processed (SHIFT state).
- `done` output 1: one-cycle pulse when `diff` and `bout` become valid.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`, registered and held until the next completion.
- `bout` output 1: final borrow; 1 iff `a < b` (unsigned), registered and held.

## Operation
- Internal state:
  - Operand shift registers `ra` and `rb`, WIDTH bits each.
  - Partial-result shift register `rd`, WIDTH bits.
  - Borrow flop `br`.
  - Bit counter, ceil(log2(WIDTH+1)) bits.
  - 2-bit FSM.
- FSM states:
  - IDLE: `busy=0`, `done=0`.
    - If `start=1`: `ra<=a`, `rb<=b`, `br<=0`, counter <= 0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: `busy=1`. Each cycle processes `x=ra[0]`, `y=rb[0]`:
    - `d = x ^ y ^ br`
    - `br <= (~x & y) | (~(x ^ y) & br)`
    - `rd <= {d, rd[WIDTH-1:1]}`; `ra` and `rb` shift right by 1; counter increments.
    - On the cycle counter == WIDTH-1, go to DONE. The output registers load in this same edge: `diff <= {d, rd[WIDTH-1:1]}` and `bout <=` the new borrow.
  - DONE: `done=1`, `busy=0` for exactly one cycle, then unconditional return to IDLE. `start` is ignored in DONE.
- `start` in SHIFT or DONE is ignored; it is not queued.
- Changes to `a` or `b` after the accepting edge have no effect on the running operation.
- `diff` and `bout` change only on the edge entering DONE (or on reset). They hold their value through IDLE and the following SHIFT.
- Reset (any state, including mid-SHIFT):
  - FSM returns to IDLE.
  - `busy=0`, `done=0`, `diff=0`, `bout=0`.
  - `ra`, `rb`, `rd`, `br` and counter are cleared.
  - The aborted operation produces no `done`.
  - `rst` has priority over `start` in the same cycle.
- WIDTH=1: SHIFT lasts one cycle; result is `a^b`, with `bout = ~a & b`.

## Timing
- Cycle 0 = cycle in which `start=1` is sampled in IDLE.
- Cycles 1..WIDTH: SHIFT, `busy=1`.
- Cycle WIDTH+1: DONE, `done=1`; `diff` and `bout` are already valid in this cycle.
- Cycle WIDTH+2: IDLE; a new `start` can be accepted here.
- Throughput: one operation per WIDTH+2 cycles with `start` held high.
- Outputs are registered; there is no combinational path from inputs to outputs.
- All outputs are 0 in the cycle after reset is applied.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, `start` in cycle 0:
  - `busy=1` in cycles 1–8.
  - `done=1` in cycle 9 only, with `diff=0x37`, `bout=0`.
  - Values held through cycle 20.
- WIDTH=8, a=0x00, b=0x01 → `diff=0xFF`, `bout=1` at cycle 9.
- a=b=0xA5 → `diff=0x00`, `bout=0`.
- a=0xFF, b=0x00 → `diff=0xFF`, `bout=0`.
- Ignored inputs: start 0x10−0x01, then pulse `start` with a=0x80, b=0x80 in cycles 3 and 9, and change `a`/`b` in cycle 4:
  - Single `done` in cycle 9 with `diff=0x0F`, `bout=0`.
  - No second operation starts.
- Reset mid-operation: start 0x5A−0x23, assert `rst` in cycle 4:
  - Cycle 5: `busy=0`, `diff=0`, `bout=0`.
  - No `done` pulse.
  - A new start 0x03−0x05 in cycle 6 gives `done` in cycle 15 with `diff=0xFE`, `bout=1`.
- Back-to-back: hold `start=1` with a=0x20, b=0x10:
  - `done` in cycles 9 and 19.
  - `diff=0x10` both times.
  - `busy` low in cycles 9–10 between the two operations.
